// File: rtl/alu_op_sequencer.sv
// Control sequencer for the bit-sliced 16-bit ALU: opcode decode, status flags and shift-add MUL.
// Optional overflow flag (CIn_msb input, VFlag output) is built when ALUCTRL_OVF_EN is defined.
module alu_op_sequencer #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CW    = 5
) (
  input  logic       Clock,
  input  logic       nReset,
  input  logic       Start,
  input  logic [3:0] Opcode,
  input  logic [3:0] ShAmt,
  input  logic       ShSrcB,
  input  logic       nZ_msb,
  input  logic       COut_msb,
  input  logic       AluMsb,
  input  logic       QLsb,
`ifdef ALUCTRL_OVF_EN
  input  logic       CIn_msb,
  output logic       VFlag,
`endif
  output logic       SUB,
  output logic       ZeroA,
  output logic       CIn,
  output logic       FAOut,
  output logic       AND,
  output logic       OR,
  output logic       XOR,
  output logic       NOT,
  output logic       NAND,
  output logic       NOR,
  output logic       Sh8,
  output logic       Sh4,
  output logic       Sh2,
  output logic       Sh1,
  output logic       ShB,
  output logic       ShL,
  output logic       ShR,
  output logic       ShOut,
  output logic       AccWr,
  output logic       MulShift,
  output logic       Busy,
  output logic       Done,
  output logic       Illegal,
  output logic       ZFlag,
  output logic       CFlag,
  output logic       NFlag
);

  typedef enum logic [2:0] {IDLE, EXEC, MCLR, MITER, FIN} state_t;

  typedef struct packed {
    logic sub, zeroa, cin, faout;
    logic land, lor, lxor, lnot, lnand, lnor;
    logic sh8, sh4, sh2, sh1, shb, shl, shr, shout;
    logic accwr, mulshift, busy, done, illegal, mul_step;
  } ctrl_t;

  state_t        state_q, state_d;
  ctrl_t         ctrl_q, ctrl_d;
  logic [3:0]    op_q, op_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          z_q, z_d, c_q, c_d, n_q, n_d;
`ifdef ALUCTRL_OVF_EN
  logic          v_q, v_d;
`endif

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    z_d     = z_q;
    c_d     = c_q;
    n_d     = n_q;
`ifdef ALUCTRL_OVF_EN
    v_d     = v_q;
`endif
    ctrl_d  = '0;

    case (state_q)
      IDLE: begin
        if (Start) begin
          op_d    = Opcode;
          state_d = (Opcode == 4'd14) ? MCLR : EXEC;
        end
      end
      EXEC: begin
        state_d = IDLE;
        if (op_q != 4'd15) begin
          z_d = ~nZ_msb;
          n_d = AluMsb;
        end
        if (op_q <= 4'd4 || op_q == 4'd13) begin
          c_d = COut_msb;
`ifdef ALUCTRL_OVF_EN
          v_d = COut_msb ^ CIn_msb;
`endif
        end
      end
      MCLR: begin
        state_d = MITER;
        cnt_d   = '0;
      end
      MITER: begin
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = FIN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      FIN: begin
        state_d = IDLE;
        z_d     = ~nZ_msb;
        n_d     = AluMsb;
        c_d     = COut_msb;
`ifdef ALUCTRL_OVF_EN
        v_d     = 1'b0;
`endif
      end
      default: state_d = IDLE;
    endcase

    // Controls are decoded for the state being entered so they leave the flops clean.
    case (state_d)
      EXEC: begin
        ctrl_d.busy    = 1'b1;
        ctrl_d.done    = 1'b1;
        ctrl_d.accwr   = (op_d != 4'd13) && (op_d != 4'd15);
        ctrl_d.illegal = (op_d == 4'd15);
        case (op_d)
          4'd0:  ctrl_d.faout = 1'b1;
          4'd1:  begin ctrl_d.faout = 1'b1; ctrl_d.cin = c_q; end
          4'd2, 4'd13: begin
            ctrl_d.faout = 1'b1; ctrl_d.sub = 1'b1; ctrl_d.cin = 1'b1;
          end
          4'd3:  begin ctrl_d.faout = 1'b1; ctrl_d.sub = 1'b1; ctrl_d.cin = c_q; end
          4'd4:  begin
            ctrl_d.faout = 1'b1; ctrl_d.sub = 1'b1; ctrl_d.zeroa = 1'b1; ctrl_d.cin = 1'b1;
          end
          4'd5:  ctrl_d.land  = 1'b1;
          4'd6:  ctrl_d.lor   = 1'b1;
          4'd7:  ctrl_d.lxor  = 1'b1;
          4'd8:  ctrl_d.lnot  = 1'b1;
          4'd9:  ctrl_d.lnand = 1'b1;
          4'd10: ctrl_d.lnor  = 1'b1;
          4'd11, 4'd12: begin
            ctrl_d.shout = 1'b1;
            ctrl_d.shl   = (op_d == 4'd11);
            ctrl_d.shr   = (op_d == 4'd12);
            ctrl_d.sh8   = ShAmt[3];
            ctrl_d.sh4   = ShAmt[2];
            ctrl_d.sh2   = ShAmt[1];
            ctrl_d.sh1   = ShAmt[0];
            ctrl_d.shb   = ShSrcB;
          end
          default: ;
        endcase
      end
      MCLR: begin
        ctrl_d.busy  = 1'b1;
        ctrl_d.zeroa = 1'b1;
        ctrl_d.faout = 1'b1;
        ctrl_d.accwr = 1'b1;
      end
      MITER: begin
        ctrl_d.busy     = 1'b1;
        ctrl_d.mulshift = 1'b1;
        ctrl_d.mul_step = 1'b1;
      end
      FIN: begin
        ctrl_d.busy = 1'b1;
        ctrl_d.done = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state_q <= IDLE;
      ctrl_q  <= '0;
      op_q    <= '0;
      cnt_q   <= '0;
      z_q     <= 1'b0;
      c_q     <= 1'b0;
      n_q     <= 1'b0;
`ifdef ALUCTRL_OVF_EN
      v_q     <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      z_q     <= z_d;
      c_q     <= c_d;
      n_q     <= n_d;
`ifdef ALUCTRL_OVF_EN
      v_q     <= v_d;
`endif
    end
  end

  // During MITER the add is qualified by the datapath's registered Q LSB.
  assign FAOut    = ctrl_q.faout | (ctrl_q.mul_step & QLsb);
  assign AccWr    = ctrl_q.accwr | (ctrl_q.mul_step & QLsb);
  assign SUB      = ctrl_q.sub;
  assign ZeroA    = ctrl_q.zeroa;
  assign CIn      = ctrl_q.cin;
  assign AND      = ctrl_q.land;
  assign OR       = ctrl_q.lor;
  assign XOR      = ctrl_q.lxor;
  assign NOT      = ctrl_q.lnot;
  assign NAND     = ctrl_q.lnand;
  assign NOR      = ctrl_q.lnor;
  assign Sh8      = ctrl_q.sh8;
  assign Sh4      = ctrl_q.sh4;
  assign Sh2      = ctrl_q.sh2;
  assign Sh1      = ctrl_q.sh1;
  assign ShB      = ctrl_q.shb;
  assign ShL      = ctrl_q.shl;
  assign ShR      = ctrl_q.shr;
  assign ShOut    = ctrl_q.shout;
  assign MulShift = ctrl_q.mulshift;
  assign Busy     = ctrl_q.busy;
  assign Done     = ctrl_q.done;
  assign Illegal  = ctrl_q.illegal;
  assign ZFlag    = z_q;
  assign CFlag    = c_q;
  assign NFlag    = n_q;
`ifdef ALUCTRL_OVF_EN
  assign VFlag    = v_q;
`endif

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Control unit for the 16-bit bit-sliced ALU built from the shared ALU slice.
- Accepts an opcode, operand-select and shift amount from the instruction decoder through a Start/Done handshake.
- Drives the one-hot slice control lines, registers the Z/C/N status flags, and sequences a 17-cycle shift-add multiply through the same ALU.
- Sits between the decoder and the ALU column.

Parameters:
- WIDTH, 16, ALU datapath width; sets the MUL iteration count.
- CW, 5, width of the MUL iteration counter; must satisfy 2^CW > WIDTH.

Ports:
- Clock  input  1  system clock, rising edge.
- nReset  input  1  asynchronous active-low reset.
- Start  input  1  request; sampled only while Busy=0.
- Opcode  input  4  operation code.
- ShAmt  input  4  shift distance for LSL/LSR.
- ShSrcB  input  1  shift B operand instead of A.
- nZ_msb  input  1  nZ chain output of the top slice.
- COut_msb  input  1  carry out of the top slice.
- AluMsb  input  1  ALUOut of the top slice.
- QLsb  input  1  multiplier LSB from the datapath Q register.
- SUB, ZeroA, CIn, FAOut  output  1 each  arithmetic controls.
- AND, OR, XOR, NOT, NAND, NOR  output  1 each  logic selects.
- Sh8, Sh4, Sh2, Sh1, ShB, ShL, ShR, ShOut  output  1 each  shifter controls.
- AccWr  output  1  write ALU result to the accumulator or destination.
- MulShift  output  1  shift the Acc:Q pair right one bit.
- Busy  output  1  operation in progress.
- Done  output  1  one-cycle completion pulse.
- Illegal  output  1  one-cycle pulse, coincident with Done, for a reserved opcode.
- ZFlag, CFlag, NFlag  output  1 each  registered status flags.

Behaviour:
- Reset: every output 0, including flags. State IDLE, all internal registers cleared.
- Reset asserted mid-operation aborts it at once. No Done is produced.
- Opcodes:
  - 0 ADD: FAOut, CIn=0.
  - 1 ADC: FAOut, CIn=CFlag.
  - 2 SUB: FAOut, SUB, CIn=1.
  - 3 SBC: FAOut, SUB, CIn=CFlag.
  - 4 NEG: FAOut, SUB, ZeroA, CIn=1.
  - 5-10: AND, OR, XOR, NOT, NAND, NOR.
  - 11 LSL: ShOut, ShL.
  - 12 LSR: ShOut, ShR.
  - 13 CMP: same controls as SUB, AccWr=0.
  - 14 MUL: multi-cycle, see below.
  - 15: reserved.
- Shift stage selects: Sh8..Sh1 = ShAmt[3..0]; ShB = ShSrcB. ShAmt=0 passes the operand through.
- Opcode, ShAmt, ShSrcB and CFlag are latched on the Start edge. Changes on these inputs while Busy=1 are ignored.
- All controls are Moore outputs decoded from the state and the latched fields. They are glitch-free and registered.
- FSM states: IDLE, EXEC, MCLR, MITER, FIN.
  - IDLE --Start & op≠14--> EXEC.
  - IDLE --Start & op=14--> MCLR.
  - EXEC --> IDLE. Done=1 and Busy=1 for the EXEC cycle. AccWr=1 unless CMP or reserved.
  - MCLR: drives ZeroA, FAOut, with B gated by the datapath to give 0. AccWr=1. Goes to MITER.
  - MITER: repeats WIDTH cycles on the counter.
    - QLsb=1: ADD controls with AccWr=1.
    - QLsb=0: FAOut, ZeroA=0, and SUB=0 are not driven; AccWr=0.
    - MulShift=1 every iteration.
    - Counter reaches WIDTH-1 → FIN.
  - FIN: Done=1 → IDLE.
- Latency:
  - Single-cycle ops: Done one cycle after Start.
  - MUL: Done at cycle WIDTH+2 after Start, i.e. 18 for WIDTH=16.
- Busy is high from the cycle after Start through the Done cycle.
- Start asserted in the same cycle as Done is ignored. A new Start is accepted only in a cycle with Busy=0.
- Flags update on the edge ending EXEC or FIN:
  - Z = ~nZ_msb.
  - N = AluMsb.
  - C = COut_msb for ops 0-4, 13 and 14 (last iteration); unchanged otherwise.
  - Reserved opcode leaves all flags unchanged.
- The MUL counter wraps to 0 on exit.

Optional Feature:
- Macro: ALUCTRL_OVF_EN.
- When defined:
  - Adds input CIn_msb and output VFlag.
  - VFlag = COut_msb ^ CIn_msb, captured for ops 0-4 and 13.
  - VFlag is cleared by MUL and unchanged by other ops.
  - VFlag resets to 0.
- When undefined: neither port exists, and flag behaviour is as above.

Test Plan:
- Reset then ADD: Opcode=0 Start. Next cycle FAOut=1, CIn=0, SUB=0, AccWr=1, Done=1. With nZ_msb=0, COut_msb=1, AluMsb=0 → Z=1, C=1, N=0.
- ADC after that ADD: Opcode=1 → CIn=1 during EXEC (CFlag=1 latched). SBC with CFlag=0 → SUB=1, CIn=0.
- LSR, ShAmt=4'b1010, ShSrcB=1 → ShOut=1, ShR=1, Sh8=1, Sh2=1, Sh4=0, Sh1=0, ShB=1. CFlag unchanged.
- MUL with QLsb toggling 1,0,1,… → MCLR cycle, then 16 MITER cycles: MulShift=1 each, AccWr=1 on odd cycles only. Done at cycle 18. Start pulses during Busy ignored.
- Opcode=15 → Done=1 and Illegal=1 in the same cycle. AccWr=0, flags unchanged.
- nReset low at MITER iteration 7 → all outputs 0 immediately, Busy=0, no Done. Next Start accepted normally.
